// File: rtl/fighter_core_if.sv
// Per-player fighter bus: action strobe and inputs from the game controller,
// fighter state back to the display and game-over logic.
interface fighter_core_if #(
  parameter int PW = 2,
  parameter int HW = 2
);
  logic          action_en;
  logic          game_over;
  logic [2:0]    my_action;
  logic [2:0]    opp_action;
  logic [PW-1:0] opp_pos;
  logic [PW-1:0] pos;
  logic [HW-1:0] health;
  logic          hit_taken;
  logic          ko;

  modport master (
    output action_en, game_over, my_action, opp_action, opp_pos,
    input  pos, health, hit_taken, ko
  );

  modport slave (
    input  action_en, game_over, my_action, opp_action, opp_pos,
    output pos, health, hit_taken, ko
  );
endinterface

// File: rtl/fighter_core.sv
// Per-player fighter engine: position, health, damage, knockback and movement.
// Idle regeneration is built only when FIGHTER_REGEN_EN is defined.
module fighter_core #(
  parameter int NPOS        = 3,
  parameter int HW          = 2,
  parameter int HMAX        = 3,
  parameter int KICK_RANGE  = 2,
  parameter int PUNCH_RANGE = 1,
  parameter int KICK_DMG    = 1,
  parameter int PUNCH_DMG   = 2,
  parameter int REGEN_WAIT  = 2,
  parameter int SIDE        = 0,
  localparam int PW         = $clog2(NPOS)
) (
  input logic           clk,
  input logic           reset,
  fighter_core_if.slave bus
);

  localparam logic [2:0] ActKick   = 3'b000;
  localparam logic [2:0] ActPunch  = 3'b001;
  localparam logic [2:0] ActJump   = 3'b011;
  localparam logic [2:0] ActLeft1  = 3'b100;
  localparam logic [2:0] ActLeft2  = 3'b101;
  localparam logic [2:0] ActRight1 = 3'b110;
  localparam logic [2:0] ActRight2 = 3'b111;

  localparam logic [PW-1:0] PosReset = (SIDE == 0) ? '0 : PW'(NPOS - 1);

  logic [PW-1:0] pos_q, pos_d;
  logic [HW-1:0] health_q, health_d;
  logic          hit_q, hit_d;
  logic          armed_q, armed_d;
  logic          ko;
  logic          act;
  logic          kick_hit, punch_hit;

  assign ko  = (health_q == '0);
  assign act = bus.action_en & armed_q & ~bus.game_over & ~ko;

  // One action per strobe: re-arm only once action_en has dropped.
  always_comb begin
    armed_d = armed_q;
    if (!bus.action_en) begin
      armed_d = 1'b1;
    end else if (act) begin
      armed_d = 1'b0;
    end
  end

  // Damage resolution uses pre-action positions of both players.
  always_comb begin
    int p, o, d;
    p = int'(pos_q);
    o = int'(bus.opp_pos);
    d = (p > o) ? (p - o) : (o - p);
    kick_hit  = (bus.opp_action == ActKick) && (d <= KICK_RANGE) &&
                (bus.my_action != ActJump);
    punch_hit = (bus.opp_action == ActPunch) && (d <= PUNCH_RANGE) &&
                (bus.my_action != ActJump) && (bus.my_action != ActPunch);
  end

  always_comb begin
    int p, o, t;
    p = int'(pos_q);
    o = int'(bus.opp_pos);
    t = p;
    if (kick_hit) begin
      // Knockback is away from the opponent; on a tie, towards own back wall.
      if (o > p || (o == p && SIDE == 0)) begin
        t = (p > 0) ? p - 1 : 0;
      end else begin
        t = (p < NPOS - 1) ? p + 1 : NPOS - 1;
      end
    end else if (o != p) begin
      unique case (bus.my_action)
        ActLeft1, ActLeft2: begin
          t = p - ((bus.my_action == ActLeft2) ? 2 : 1);
          if (t < 0) t = 0;
          if (o < p && t <= o) t = o + 1;
        end
        ActRight1, ActRight2: begin
          t = p + ((bus.my_action == ActRight2) ? 2 : 1);
          if (t > NPOS - 1) t = NPOS - 1;
          if (o > p && t >= o) t = o - 1;
        end
        default: t = p;
      endcase
    end
    pos_d = act ? PW'(t) : pos_q;
  end

`ifdef FIGHTER_REGEN_EN
  localparam logic [2:0] ActAwait = 3'b010;
  localparam int         WW       = (REGEN_WAIT < 2) ? 1 : $clog2(REGEN_WAIT + 1);

  logic [WW-1:0] wait_q, wait_d;

  always_comb begin
    int h;
    h = int'(health_q);
    wait_d = wait_q;
    if (kick_hit) begin
      h = (h > KICK_DMG) ? h - KICK_DMG : 0;
    end else if (punch_hit) begin
      h = (h > PUNCH_DMG) ? h - PUNCH_DMG : 0;
    end
    if (kick_hit || punch_hit || bus.my_action != ActAwait) begin
      wait_d = '0;
    end else if (int'(wait_q) + 1 >= REGEN_WAIT) begin
      wait_d = '0;
      if (h < HMAX) h = h + 1;
    end else begin
      wait_d = wait_q + 1'b1;
    end
    if (!act) begin
      h      = int'(health_q);
      wait_d = wait_q;
    end
    health_d = HW'(h);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic unused_regen;
  assign unused_regen = (REGEN_WAIT != 0);

  always_comb begin
    int h;
    h = int'(health_q);
    if (act && kick_hit) begin
      h = (h > KICK_DMG) ? h - KICK_DMG : 0;
    end else if (act && punch_hit) begin
      h = (h > PUNCH_DMG) ? h - PUNCH_DMG : 0;
    end
    health_d = HW'(h);
  end
`endif

  assign hit_d = act & (kick_hit | punch_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q    <= PosReset;
      health_q <= HW'(HMAX);
      hit_q    <= 1'b0;
      armed_q  <= 1'b1;
    end else begin
      pos_q    <= pos_d;
      health_q <= health_d;
      hit_q    <= hit_d;
      armed_q  <= armed_d;
    end
  end

  assign bus.pos       = pos_q;
  assign bus.health    = health_q;
  assign bus.hit_taken = hit_q;
  assign bus.ko        = ko;

endmodule

// File: doc/fighter_core.md
Name: fighter_core

Overview:
- Parametrised per-player fighter engine for the two-player arcade game; one instance per player, mirrored with SIDE.
- Tracks arena position (binary index over NPOS cells), health, and idle-regen.
- Resolves one action per action_en pulse against the opponent's action and position.
- Feeds the game-over detector and display; replaces the fixed 3-cell/2-bit player blocks.

Parameters:
- NPOS, 3: arena cells, indexed 0 (left wall) to NPOS-1 (right wall); range 2..16.
- HW, 2: health width.
- HMAX, 3: reset/maximum health; must be <= 2^HW-1.
- KICK_RANGE, 2: kick reaches opponent if distance <= KICK_RANGE.
- PUNCH_RANGE, 1: punch reach.
- KICK_DMG, 1: damage from a landed kick.
- PUNCH_DMG, 2: damage from a landed punch.
- REGEN_WAIT, 2: consecutive awaits needed for +1 health.
- SIDE, 0: 0 = starts at cell 0, faces right; 1 = starts at cell NPOS-1, faces left.
- Derived localparam PW = clog2(NPOS).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- action_en  in  1  action strobe; one action resolved per high phase
- game_over  in  1  freezes all state when high
- my_action  in  3  own action: kick 000, punch 001, await 010, jump 011, left1 100, left2 101, right1 110, right2 111
- opp_action  in  3  opponent action, same encoding
- opp_pos  in  PW  opponent cell index (pre-action value)
- pos  out  PW  own cell index
- health  out  HW  own health
- hit_taken  out  1  one-cycle pulse when damage is applied
- ko  out  1  high while health == 0

Behaviour:
- Reset (reset low, async): pos = 0 if SIDE=0, else NPOS-1; health = HMAX; wait_cnt = 0; hit_taken = 0; armed = 1.
- Action cycle: rising clk with action_en=1, armed=1, game_over=0, ko=0.
  - Sets armed=0.
  - armed returns to 1 on any clk where action_en=0.
  - Holding action_en high for N cycles yields exactly one action.
- Outside an action cycle, pos, health and wait_cnt hold; hit_taken = 0.
- Distance: d = |pos - opp_pos|, using pre-action values only (both instances resolve simultaneously).
- Damage taken (evaluated first):
  - Kick hits if opp_action=kick, d <= KICK_RANGE, my_action != jump.
  - Punch hits if opp_action=punch, d <= PUNCH_RANGE, my_action not in {jump, punch}; punch vs punch is a clash, no damage.
  - Health decrements by the damage amount, saturating at 0.
  - Sets hit_taken=1 for that cycle and clears wait_cnt.
- Movement:
  - left1/right1 move 1 cell; left2/right2 move 2 cells.
  - Saturate at walls 0 and NPOS-1.
  - Never enter or pass opp_pos: clamp to the adjacent cell on own side. If already adjacent, hold.
- Knockback:
  - A landed kick pushes pos one cell away from the opponent, clamped at the wall.
  - Knockback overrides own movement that cycle.
  - A landed punch causes no knockback.
- Regen:
  - On await with no hit, wait_cnt increments.
  - When it reaches REGEN_WAIT: health = min(health+1, HMAX) and wait_cnt = 0. At HMAX, wait_cnt still clears.
  - Any non-await action clears wait_cnt.
- ko is combinational from health. Once ko=1 the block ignores actions until reset.
- game_over high during an action_en pulse: no action; armed is unaffected.
- All arithmetic is unsigned with explicit saturation; no wrap-around of health or pos.

Optional Feature:
- Macro FIGHTER_REGEN_EN.
- Defined: regen behaves as above.
- Undefined: no wait_cnt register; await is a pure no-op; health never increases except on reset.

Test Plan:
- Reset, SIDE=0, defaults -> pos=0, health=3, ko=0, hit_taken=0. Drive action_en high 5 cycles with right1 -> pos=1 exactly once.
- pos=1, opp_pos=2, opp kick, my await -> health 3->2, hit_taken pulses 1 cycle, pos=0 (knockback).
- pos=1, opp_pos=2, both punch -> no damage. Repeat with my kick, opp punch -> health 3->1.
- pos=0, opp_pos=2, right2 -> pos=1 (clamped before opponent). left1 at pos=0 -> stays 0.
- health=1, two await actions, no hits -> health=2 on the second action. A third await then a hit -> wait_cnt cleared, health 2->1. With the macro undefined -> health stays 1.
- health=1, opp punch in range -> health=0, ko=1, later actions ignored. game_over=1 with action_en pulse -> state unchanged.
